// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Step counter width; a single-digit operation still needs one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_digit.sv
// Combinational DIGIT-bit ripple of full-subtractor cells: d = x - y - bi.
module fs_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] w_br;

  assign w_br[0] = bi;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign d[i]        = x[i] ^ y[i] ^ w_br[i];
    // Borrow when y beats x outright, or they tie and a borrow is pending.
    assign w_br[i+1]   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_br[i]);
  end

  assign bo = w_br[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, DIGIT bits per clock, LSB digit first.
// Optional signed overflow flag enabled by defining SIGNED_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_subtractor: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_d, r_diff;
  logic             r_bor, r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT-1:0] w_dig;
  logic             w_bo, w_last;
  logic [WIDTH-1:0] w_dext, w_dnext;

  fs_digit #(.DIGIT(DIGIT)) u_fs (
    .x  (r_a[DIGIT-1:0]),
    .y  (r_b[DIGIT-1:0]),
    .bi (r_bor),
    .d  (w_dig),
    .bo (w_bo)
  );

  assign w_last  = (r_cnt == CW'(N - 1));
  // New digit enters at the MSB end so the LSB digit lands at bit 0 after N steps.
  assign w_dext  = WIDTH'(w_dig);
  assign w_dnext = (r_d >> DIGIT) | (w_dext << (WIDTH - DIGIT));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_bor    <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_a   <= a;
          r_b   <= b;
          r_bor <= bin;
          r_d   <= '0;
          r_cnt <= '0;
        end
        S_RUN: begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_d   <= w_dnext;
          r_bor <= w_bo;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff   <= w_dnext;
            r_borrow <= w_bo;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SIGNED_OVF_EN
  logic r_as, r_bs, r_ovf;

  // Operand signs are captured at accept because the shift regs lose them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_as  <= 1'b0;
      r_bs  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_as <= a[WIDTH-1];
      r_bs <= b[WIDTH-1];
    end else if (r_state == S_RUN && w_last) begin
      r_ovf <= (r_as != r_bs) && (w_dnext[WIDTH-1] != r_as);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign ready  = (r_state == S_IDLE);
  assign done   = (r_state == S_DONE);
  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule
